// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Integer truncation; the residual error is absorbed by mid-bit sampling.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, parity, 1 stop; shows the last good
// byte on LEDR and the parity verdict of that frame on check_parity.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 125000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       CLOCK_125_p,
    input  logic       CPU_RESET_n,
    input  logic       SW,
    output logic [7:0] LEDR,
    output logic       check_parity
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CW  = $clog2(CPB);
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);

    logic rx;

    uart_sync u_sync (
        .clk   (CLOCK_125_p),
        .rst_n (CPU_RESET_n),
        .d     (SW),
        .q     (rx)
    );

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          err_q, err_d;
    logic [7:0]    led_q, led_d;
    logic          par_q, par_d;

    always_ff @(posedge CLOCK_125_p or negedge CPU_RESET_n) begin
        if (!CPU_RESET_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            led_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            led_q   <= led_d;
            par_q   <= par_d;
        end
    end

    // The baud counter free-runs inside a bit and restarts at every sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        err_d   = err_q;
        led_d   = led_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d   = '0;
                    err_d   = (^shift_q) ^ rx ^ PARITY_SENSE;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CPB_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        led_d   = shift_q;
                        par_d   = err_q;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign LEDR         = led_q;
    assign check_parity = par_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at a shortened bit period (125 clocks per bit).
module tb_uart_receiver;

    localparam int unsigned CLK_FREQ = 125000000;
    localparam int unsigned BAUD     = 1000000;
    localparam int unsigned CPB      = CLK_FREQ / BAUD;
    localparam int unsigned HALF     = CPB / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw    = 1'b1;
    logic [7:0] ledr;
    logic       check_parity;

    always #4 clk = ~clk;

    uart_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .PARITY_ODD (0)
    ) dut (
        .CLOCK_125_p  (clk),
        .CPU_RESET_n  (rst_n),
        .SW           (sw),
        .LEDR         (ledr),
        .check_parity (check_parity)
    );

    typedef struct {
        int unsigned due;
        logic [7:0]  led;
        logic        par;
        logic [7:0]  prev_led;
        logic        prev_par;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  model_led = 8'h00;
    logic        model_par = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Outputs must hold right up to the stop sample and change just after it.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (cyc == sb[0].due - 1) begin
                check_val("pre_led", 32'(ledr), 32'(sb[0].prev_led));
                check_val("pre_par", 32'(check_parity), 32'(sb[0].prev_par));
            end else if (cyc == sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                check_val("led", 32'(ledr), 32'(e.led));
                check_val("par", 32'(check_parity), 32'(e.par));
            end
        end
    end

    // Called at a negedge; the stop sample lands 3 + HALF + 10*CPB posedges later.
    task automatic push_expect(input logic accept, input logic [7:0] data, input logic exp_err);
        exp_t e;
        e.due      = cyc + 3 + HALF + 10 * CPB;
        e.prev_led = model_led;
        e.prev_par = model_par;
        if (accept) begin
            model_led = data;
            model_par = exp_err;
        end
        e.led = model_led;
        e.par = model_par;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int unsigned low_tail, input logic exp_err);
        push_expect(stop, data, exp_err);
        sw = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sw = data[i];
            repeat (CPB) @(negedge clk);
        end
        sw = par;
        repeat (CPB) @(negedge clk);
        sw = stop;
        repeat (CPB) @(negedge clk);
        repeat (low_tail * CPB) @(negedge clk);
        sw = 1'b1;
    endtask

    task automatic idle_bits(input int unsigned n);
        repeat (n * CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;
        #100;
        check_val("rst_led", 32'(ledr), 32'h00);
        check_val("rst_par", 32'(check_parity), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(22);
        check_val("idle_led", 32'(ledr), 32'h00);
        check_val("idle_par", 32'(check_parity), 32'h0);

        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1);
        send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
        idle_bits(2);

        // Short low pulse: rejected at the start check, nothing changes.
        push_expect(1'b0, 8'h00, 1'b0);
        sw = 1'b0;
        repeat (25) @(negedge clk);
        sw = 1'b1;
        idle_bits(12);
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        idle_bits(1);

        send_frame(8'h7E, 1'b0, 1'b0, 2, 1'b0);
        idle_bits(1);
        send_frame(8'hFF, 1'b1, 1'b1, 0, 1'b1);
        idle_bits(2);

        // Reset in the middle of data bit 4 of 0x55.
        partial = 8'h55;
        sw = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sw = partial[i];
            repeat (CPB) @(negedge clk);
        end
        sw = partial[4];
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_led", 32'(ledr), 32'h00);
        check_val("abort_par", 32'(check_parity), 32'h0);
        model_led = 8'h00;
        model_par = 1'b0;
        @(negedge clk);
        sw = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(12);
        check_val("post_rst_led", 32'(ledr), 32'h00);
        send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
        idle_bits(2);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
